// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and store-lane helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISALIGN = 2'd1,
    FC_ILLEGAL  = 2'd2,
    FC_TIMEOUT  = 2'd3
  } fault_cause_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Major opcodes, also decoded by control_unit.
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;

  // Fault classification of a request before any bus activity; illegal wins over misaligned.
  function automatic fault_cause_t classify(input logic st, input logic [2:0] f3,
                                            input logic [1:0] a);
    logic illegal;
    logic misal;
    if (st) illegal = (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W);
    else    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    case (f3[1:0])
      2'b01:   misal = a[0];
      2'b10:   misal = (a != 2'b00);
      default: misal = 1'b0;
    endcase
    if (illegal)    return FC_ILLEGAL;
    else if (misal) return FC_MISALIGN;
    else            return FC_NONE;
  endfunction

  // Byte enables for a store of width f3 at byte offset a.
  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_B:    return 4'b0001 << a;
      F3_H:    return a[1] ? 4'b1100 : 4'b0011;
      F3_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Store data replicated across every lane the width can occupy.
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      F3_B:    return {4{d[7:0]}};
      F3_H:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Selects the addressed byte/halfword of a read word and extends it to 32 bits.
module lsu_load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection followed by sign or zero extension.
  always_comb begin
    byte_sel = mem_rdata[8*addr_lo +: 8];
    half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_HU:   load_data = {16'd0, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: runs one load/store at a time over a valid/ready data bus.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        stall,
  output logic        done,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata
);

  // Counter value seen in the last permitted WAIT cycle.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_t   state, state_nxt;
  fault_cause_t cause_q;
  logic         cap_store;
  logic [2:0]   cap_f3;
  logic [1:0]   addr_lo_q;
  logic [4:0]   cap_rd;
  logic [7:0]   cnt;
  logic         mem_we_q;
  logic [31:0]  mem_addr_q;
  logic [31:0]  mem_wdata_q;
  logic [3:0]   mem_wstrb_q;
  logic [31:0]  wb_data_q;
  logic [31:0]  ext_data;

  lsu_load_extract u_extract (
    .mem_rdata (mem_rdata),
    .addr_lo   (addr_lo_q),
    .funct3    (cap_f3),
    .load_data (ext_data)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: faults skip the bus, stores are posted, loads wait for data or timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid)
              state_nxt = (classify(is_store, funct3, addr[1:0]) != FC_NONE) ? DONE : REQ;
      REQ:  if (mem_req_ready) state_nxt = cap_store ? DONE : WAIT;
      WAIT: if (mem_resp_valid || (cnt == TO_LAST)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, bus request fields, wait counter and load result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cause_q     <= FC_NONE;
      cap_store   <= 1'b0;
      cap_f3      <= 3'd0;
      addr_lo_q   <= 2'd0;
      cap_rd      <= 5'd0;
      cnt         <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'd0;
      wb_data_q   <= 32'd0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          cap_store   <= is_store;
          cap_f3      <= funct3;
          addr_lo_q   <= addr[1:0];
          cap_rd      <= rd;
          cnt         <= 8'd0;
          cause_q     <= classify(is_store, funct3, addr[1:0]);
          mem_we_q    <= is_store;
          mem_addr_q  <= {addr[31:2], 2'b00};
          mem_wdata_q <= store_wdata(funct3, store_data);
          mem_wstrb_q <= is_store ? store_strb(funct3, addr[1:0]) : 4'b0000;
        end
        REQ: if (mem_req_ready) cnt <= 8'd0;
        WAIT: begin
          if (mem_resp_valid)       wb_data_q <= ext_data;
          else if (cnt == TO_LAST)  cause_q   <= FC_TIMEOUT;
          else                      cnt       <= cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and captured fields.
  always_comb begin
    req_ready     = (state == IDLE);
    mem_req_valid = (state == REQ);
    done          = (state == DONE);
    wb_valid      = (state == DONE) && !cap_store && (cause_q == FC_NONE);
    fault         = (state == DONE) && (cause_q != FC_NONE);
    fault_cause   = (state == DONE) ? cause_q : 2'd0;
    stall         = req_valid && (state != DONE);
    wb_rd         = cap_rd;
    wb_data       = wb_data_q;
    mem_we        = mem_we_q;
    mem_addr      = mem_addr_q;
    mem_wdata     = mem_wdata_q;
    mem_wstrb     = mem_wstrb_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a byte-addressed reference memory.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk, rst_n;
  logic        req_valid, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic [4:0]  rd;
  logic        req_ready, stall, done, wb_valid, fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  fault_cause;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .is_store(is_store), .funct3(funct3), .addr(addr), .store_data(store_data), .rd(rd),
    .stall(stall), .done(done), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .fault(fault), .fault_cause(fault_cause), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        wbv;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        flt;
    logic [1:0]  cause;
    int          dcyc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } bus_t;

  exp_t        exp_q[$];
  bus_t        bus_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [7:0]  ref_mem [64];
  logic [31:0] bus_mem [16];
  int          rdly = 0;
  int          lat = 1;
  bit          in_flight = 0;
  bit          stray_now = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic set_word(input int idx, input logic [31:0] w);
    bus_mem[idx] = w;
    for (int k = 0; k < 4; k++) ref_mem[idx*4 + k] = w[8*k +: 8];
  endtask

  // Bus slave: programmable ready delay, response latency (0 = never respond), stray responses.
  initial begin
    int  wcnt = 0;
    int  rcnt = 0;
    bit  pend = 0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'd0;
    forever begin
      @(negedge clk); #1;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_rdata      = $urandom;
      if (!rst_n) begin
        pend = 0; wcnt = 0;
      end else if (stray_now) begin
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hFFFF_FFFF;
      end else if (pend) begin
        rcnt--;
        if (rcnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_rdata      = bus_mem[mem_addr[5:2]];
          pend = 0;
        end
      end else if (mem_req_valid) begin
        if (wcnt < rdly) wcnt++;
        else begin
          mem_req_ready = 1'b1;
          wcnt = 0;
          if (mem_we) begin
            for (int k = 0; k < 4; k++)
              if (mem_wstrb[k]) bus_mem[mem_addr[5:2]][8*k +: 8] = mem_wdata[8*k +: 8];
          end else if (lat > 0) begin
            pend = 1; rcnt = lat;
          end
        end
      end else if (!in_flight && ($urandom_range(0, 3) == 0)) begin
        mem_resp_valid = 1'b1;
      end
    end
  end

  // Completion and bus monitors.
  initial begin
    exp_t e;
    bus_t b;
    forever begin
      @(negedge clk); #3;
      if (rst_n) begin
        if (done) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_done: got done=1, expected no completion (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("done_cycle", cyc, e.dcyc);
            chk("wb_valid", {31'd0, wb_valid}, {31'd0, e.wbv});
            chk("fault", {31'd0, fault}, {31'd0, e.flt});
            chk("fault_cause", {30'd0, fault_cause}, {30'd0, e.cause});
            if (e.wbv) begin
              chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
              chk("wb_data", wb_data, e.data);
            end
          end
        end else begin
          chk("idle_wb_fault", {30'd0, wb_valid, fault}, 32'd0);
        end
        if (mem_req_valid) begin
          if (bus_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_bus_req: got mem_req_valid=1 addr %h, expected none", mem_addr);
          end else begin
            b = bus_q[0];
            chk("mem_we", {31'd0, mem_we}, {31'd0, b.we});
            chk("mem_addr", mem_addr, b.addr);
            chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, b.strb});
            if (b.we) chk("mem_wdata", mem_wdata, b.wdata);
            if (mem_req_ready) void'(bus_q.pop_front());
          end
        end
      end
    end
  end

  // Issue one request, queue its expected outcome from the reference memory, wait for done.
  task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] r,
                        input int rd_dly, input int latency);
    exp_t e;
    bus_t b;
    int   n, off, base;
    bit   illegal, misal, got;
    n = 1 << f3[1:0];
    off = int'(a[1:0]);
    base = int'(a[5:0]);
    illegal = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    misal = (off % n) != 0;
    e.rd = r; e.data = 32'd0; e.wbv = 1'b0; e.flt = 1'b0; e.cause = 2'd0;
    b.we = st; b.addr = {a[31:2], 2'b00}; b.wdata = 32'd0; b.strb = 4'd0;
    if (illegal || misal) begin
      e.flt = 1'b1;
      e.cause = illegal ? 2'd2 : 2'd1;
      e.dcyc = 1;
    end else if (st) begin
      for (int k = 0; k < 4; k++) b.wdata[8*k +: 8] = d[8*(k % n) +: 8];
      for (int k = 0; k < n; k++) begin
        b.strb[off + k] = 1'b1;
        ref_mem[base + k] = d[8*k +: 8];
      end
      e.dcyc = 2 + rd_dly;
      bus_q.push_back(b);
    end else begin
      bus_q.push_back(b);
      if (latency == 0 || latency > TO) begin
        e.flt = 1'b1; e.cause = 2'd3; e.dcyc = 2 + rd_dly + TO;
      end else begin
        for (int k = 0; k < n; k++) e.data[8*k +: 8] = ref_mem[base + k];
        if (!f3[2] && n == 1) e.data = {{24{e.data[7]}}, e.data[7:0]};
        if (!f3[2] && n == 2) e.data = {{16{e.data[15]}}, e.data[15:0]};
        e.wbv = 1'b1;
        e.dcyc = 2 + rd_dly + latency;
      end
    end
    rdly = rd_dly; lat = latency; in_flight = 1;
    @(negedge clk); #1;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = d; rd = r;
    e.dcyc += cyc;
    exp_q.push_back(e);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk); #1;
      if (done) got = 1;
      else chk("stall_busy", {31'd0, stall}, 32'd1);
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no done within 40 cycles, expected completion");
    end else chk("stall_done", {31'd0, stall}, 32'd0);
    req_valid = 1'b0;
    in_flight = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  // Directed scenarios first, then a randomized stream.
  initial begin
    logic [2:0] f3;
    rst_n = 1'b0;
    req_valid = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0; store_data = 32'd0; rd = 5'd0;
    for (int i = 0; i < 16; i++) set_word(i, $urandom);
    #2;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_outputs", {26'd0, done, wb_valid, fault, mem_req_valid, mem_we, stall}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    set_word(0, 32'h80FF_1234);
    do_req(1'b0, 3'b000, 32'h0000_0103, 32'd0, 5'd7, 0, 1);           // LB sign extension
    do_req(1'b1, 3'b001, 32'h0000_0022, 32'h0000_BEEF, 5'd0, 0, 1);   // SH upper half
    do_req(1'b0, 3'b001, 32'h0000_0022, 32'd0, 5'd9, 0, 1);           // read back 0xBEEF signed
    do_req(1'b0, 3'b010, 32'h0000_0041, 32'd0, 5'd3, 0, 1);           // misaligned LW
    do_req(1'b0, 3'b011, 32'h0000_0040, 32'd0, 5'd3, 0, 1);           // illegal load funct3
    do_req(1'b1, 3'b101, 32'h0000_0040, 32'd0, 5'd3, 0, 1);           // illegal store funct3
    do_req(1'b0, 3'b010, 32'h0000_0044, 32'd0, 5'd4, 5, 0);           // backpressure + timeout
    do_req(1'b0, 3'b010, 32'h0000_0048, 32'd0, 5'd5, 1, TO);          // response on last cycle

    // Reset while waiting for a response that never comes.
    bus_q.push_back('{we: 1'b0, addr: 32'h0000_0200, wdata: 32'd0, strb: 4'd0});
    rdly = 0; lat = 0; in_flight = 1;
    @(negedge clk); #1;
    req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0200; rd = 5'd1;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_outputs", {27'd0, done, wb_valid, fault, mem_req_valid, mem_we}, 32'd0);
    chk("midrst_fields", {mem_wstrb, 26'd0, fault_cause}, 32'd0);
    chk("midrst_wb_data", wb_data, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    #1 stray_now = 1;
    @(negedge clk); #2 stray_now = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      chk("stray_no_wb", {30'd0, wb_valid, done}, 32'd0);
    end
    in_flight = 0;
    set_word(0, 32'h0000_0080);
    do_req(1'b0, 3'b100, 32'h0000_0300, 32'd0, 5'd12, 0, 1);          // LBU after recovery

    for (int t = 0; t < 150; t++) begin
      bit st;
      int l;
      st = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (st) f3 = 3'($urandom_range(0, 2));
      else begin
        l = $urandom_range(0, 4);
        f3 = (l == 3) ? 3'b100 : (l == 4) ? 3'b101 : 3'(l);
      end
      l = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO);
      do_req(st, f3, $urandom, $urandom, 5'($urandom), $urandom_range(0, 3), l);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk); #1;
        chk("stall_idle", {31'd0, stall}, 32'd0);
      end
    end

    repeat (4) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("bus_q_drained", bus_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage placed directly downstream of the ALU in the RV32I core.
- Consumes the ALU result as the effective address and rs2 as store data.
- Executes LB/LH/LW/LBU/LHU/SB/SH/SW over a valid/ready data-memory bus with variable latency.
- Returns aligned, extended load data for register write-back and stalls the core while busy.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in WAIT before the response is declared lost. Legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; 0 = in reset
- req_valid  input  1  core presents a memory instruction; held until done
- req_ready  output  1  unit can accept a request
- is_store  input  1  1 = store, 0 = load
- funct3  input  3  RV32I width/sign field
- addr  input  32  effective address (ALU result)
- store_data  input  32  rs2 value
- rd  input  5  destination register for loads
- stall  output  1  core must hold PC and pipeline inputs
- done  output  1  one-cycle completion pulse
- wb_valid  output  1  load data valid (coincides with done)
- wb_rd  output  5  write-back register
- wb_data  output  32  extended load data
- fault  output  1  request terminated with error (coincides with done)
- fault_cause  output  2  0 none, 1 misaligned, 2 illegal funct3, 3 timeout
- mem_req_valid  output  1  bus request valid
- mem_req_ready  input  1  bus accepts request
- mem_we  output  1  bus write
- mem_addr  output  32  word address, {addr[31:2],2'b00}
- mem_wdata  output  32  lane-replicated store data
- mem_wstrb  output  4  byte enables; 0000 for reads
- mem_resp_valid  input  1  read data valid
- mem_rdata  input  32  read word

Behaviour:
- States: IDLE, REQ, WAIT, DONE.
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, except req_ready=1.
  - Captured fields and the timeout counter clear.
  - An in-flight bus transaction is abandoned. A later mem_resp_valid is ignored because the unit is not in WAIT.
- IDLE:
  - req_ready=1.
  - On req_valid, capture is_store, funct3, addr, store_data and rd.
  - Illegal funct3 (loads: 3, 6, 7; stores: 3..7) goes to DONE with fault cause 2.
  - Misaligned access (halfword with addr[0]=1; word with addr[1:0]≠0) goes to DONE with fault cause 1.
  - Faulting requests issue no bus transaction.
  - Otherwise go to REQ.
- REQ:
  - mem_req_valid=1; mem_addr, mem_we, mem_wdata and mem_wstrb are registered and stable until the handshake.
  - On mem_req_ready: a store goes to DONE (posted write); a load goes to WAIT and the counter clears.
- WAIT:
  - Counter increments each cycle.
  - The earliest legal response is the cycle after the request handshake.
  - On mem_resp_valid, register wb_data and go to DONE.
  - If the counter reaches TIMEOUT_CYCLES with no response, go to DONE with fault cause 3.
  - If mem_resp_valid and the timeout occur in the same cycle, the response wins.
- DONE:
  - For exactly one cycle: done=1; wb_valid=1 only for a successful load; fault and fault_cause driven.
  - req_ready=0, so the still-asserted req_valid is not re-accepted.
  - Next state is IDLE.
- stall = req_valid & (state≠DONE), combinational.
- mem_resp_valid outside WAIT is ignored.
- Store lanes, with b = addr[1:0]:
  - SB: wstrb = 0001<<b; wdata = byte replicated ×4.
  - SH: wstrb = 0011 if addr[1]=0, else 1100; wdata = halfword replicated ×2.
  - SW: wstrb = 1111.
- Load extraction: select byte b or halfword addr[1] from mem_rdata.
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Latency:
  - Store with mem_req_ready high: done 2 cycles after acceptance.
  - Load with ready high and a 1-cycle response: done 3 cycles after acceptance.
  - Fault: done 1 cycle after acceptance.

Decomposition:
- lsu_pkg holds:
  - lsu_state_t enum (IDLE, REQ, WAIT, DONE).
  - fault_cause_t enum.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Store-opcode constant 7'b0100011 and load-opcode constant 7'b0000011, shared with control_unit.
- Sub-module lsu_load_extract is combinational: inputs mem_rdata, addr[1:0], funct3; output 32-bit extended data.

Test Plan:
- Check 1, LB sign extension: LB at addr 0x103, mem_rdata 0x80FF_1234, 1-cycle response → done 3 cycles after acceptance, wb_data=0xFFFF_FF80, mem_wstrb=0000, mem_addr=0x100.
- Check 2, SH upper half: SH at addr 0x22, store_data 0x0000_BEEF → mem_wstrb=1100, mem_wdata=0xBEEF_BEEF, mem_we=1, done 2 cycles after acceptance, wb_valid=0.
- Check 3, misaligned word: LW at addr 0x41 → no mem_req_valid, done+fault with fault_cause=1 one cycle after acceptance.
- Check 4, illegal funct3: load with funct3=3 → fault_cause=2, no bus transaction.
- Check 5, backpressure and timeout:
  - mem_req_ready low for 5 cycles → request fields stable, stall held high throughout.
  - With TIMEOUT_CYCLES=4 and no response → fault_cause=3 after 4 WAIT cycles.
- Check 6, reset mid-operation:
  - Assert reset during WAIT → immediate IDLE with outputs cleared.
  - A mem_resp_valid arriving after reset release produces no wb_valid.
  - LBU of 0x80 after recovery → wb_data=0x0000_0080.
